// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the line-burst memory responder.
//   rd_state_t        : read-side FSM states (fetch a line, serialise beats)
//   wr_state_t        : write-side FSM states (collect beats, commit a line)
//   line_offset_bits  : number of byte-offset address bits inside one line
package mem_burst_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, BURST} rd_state_t;

  typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_COMMIT} wr_state_t;

  function automatic int line_offset_bits(input int line_w);
    return $clog2(line_w / 8);
  endfunction

endpackage

// File: rtl/burst_req_fifo.sv
// Read-request address FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   push, din  : enqueue an address
//   pop, dout  : dequeue the head; dout always shows the current head
//   full, empty: occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate counter. A push while full is taken only when a pop
// frees the slot in the same cycle.
module burst_req_fifo #(
  parameter int ADDR_W = 32,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] din,
  input  logic              pop,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(QDEPTH);

  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [ADDR_W-1:0] mem [QDEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/mem_burst_responder.sv
// Line-burst memory responder.
//   clk, rst_n           : clock, asynchronous active-low reset
//   read, write, addr    : line-aligned requests; write carries one beat/cycle
//   wdata                : write beat data
//   ready                : request acceptance
//   raddr, rdata, rvalid : read burst return, BEATS beats per line, in order
//   error                : sticky protocol error flag
//   src_req, src_addr    : one-cycle line fetch request to the backing store
//   src_valid, src_line  : fetched line
//   snk_we, snk_addr,
//   snk_line             : one-cycle line commit to the backing store
// Reads are queued (up to QDEPTH) and served one line at a time; a write
// line is held in W_COMMIT until every earlier read has been fetched.
module mem_burst_responder
  import mem_burst_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int BEAT_W  = 64,
  parameter int BEATS   = 4,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [BEAT_W-1:0]         wdata,
  output logic                      ready,
  output logic [ADDR_W-1:0]         raddr,
  output logic [BEAT_W-1:0]         rdata,
  output logic                      rvalid,
  output logic                      error,
  output logic                      src_req,
  output logic [ADDR_W-1:0]         src_addr,
  input  logic                      src_valid,
  input  logic [BEAT_W*BEATS-1:0]   src_line,
  output logic                      snk_we,
  output logic [ADDR_W-1:0]         snk_addr,
  output logic [BEAT_W*BEATS-1:0]   snk_line
);

  localparam int OFF_W  = line_offset_bits(BEAT_W * BEATS);
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LCNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(BEATS - 1);
  localparam logic [LCNT_W-1:0] LAT_LAST  = LCNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  rd_state_t rd_state, rd_next;
  wr_state_t wr_state, wr_next;

  logic                           fifo_push;
  logic                           fifo_pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [ADDR_W-1:0]              fifo_dout;

  logic [ADDR_W-1:0]              cur_addr;
  logic                           src_req_q;
  logic [LCNT_W-1:0]              lat_cnt;
  logic [BCNT_W-1:0]              beat_cnt;
  logic [BEATS-1:0][BEAT_W-1:0]   line_q;

  logic [ADDR_W-1:0]              wr_addr_q;
  logic [BCNT_W-1:0]              wcnt;
  logic [BEATS-1:0][BEAT_W-1:0]   wline_q;
  logic                           wr_cap0;
  logic                           wr_cap;

  logic                           aligned;
  logic                           err_now;
  logic                           error_q;

  assign aligned   = (addr[OFF_W-1:0] == '0);
  assign ready     = !fifo_full && (wr_state == W_IDLE);
  // Only a clean, aligned, read-only request is queued; anything else is dropped.
  assign fifo_push = read && ready && !write && aligned;

  assign err_now = (read && write)
                || ((read || write) && !aligned)
                || (read && !ready)
                || ((wr_state == W_COLLECT) && (addr != wr_addr_q))
                || ((wr_state == W_COLLECT) && !write);

  burst_req_fifo #(
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (addr),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Read side: fetch one line, wait LATENCY cycles, emit BEATS beats.
  always_comb begin
    rd_next  = rd_state;
    fifo_pop = 1'b0;
    unique case (rd_state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          rd_next  = FETCH;
        end
      end
      FETCH: if (src_valid) rd_next = (LATENCY > 0) ? WAIT : BURST;
      WAIT:  if (lat_cnt == LAT_LAST) rd_next = BURST;
      BURST: if (beat_cnt == BEAT_LAST) rd_next = IDLE;
      default: rd_next = IDLE;
    endcase
  end

  // Write side: beat 0 in W_IDLE, remaining beats in W_COLLECT, then commit
  // once no earlier read is still queued or being fetched.
  always_comb begin
    wr_next = wr_state;
    wr_cap0 = 1'b0;
    wr_cap  = 1'b0;
    snk_we  = 1'b0;
    unique case (wr_state)
      W_IDLE: begin
        if (write && ready && aligned) begin
          wr_cap0 = 1'b1;
          wr_next = W_COLLECT;
        end
      end
      W_COLLECT: begin
        if (!write) begin
          wr_next = W_IDLE;
        end else begin
          wr_cap = 1'b1;
          if (wcnt == BEAT_LAST) wr_next = W_COMMIT;
        end
      end
      W_COMMIT: begin
        if (fifo_empty && (rd_state != FETCH)) begin
          snk_we  = 1'b1;
          wr_next = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state  <= IDLE;
      wr_state  <= W_IDLE;
      cur_addr  <= '0;
      src_req_q <= 1'b0;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      wcnt      <= '0;
      error_q   <= 1'b0;
    end else begin
      rd_state  <= rd_next;
      wr_state  <= wr_next;
      // src_req covers only the first FETCH cycle, i.e. the cycle after the pop.
      src_req_q <= fifo_pop;
      if (fifo_pop) cur_addr <= fifo_dout;
      lat_cnt   <= (rd_state == WAIT)  ? lat_cnt + 1'b1  : '0;
      beat_cnt  <= (rd_state == BURST) ? beat_cnt + 1'b1 : '0;
      if (wr_cap0)     wcnt <= BCNT_W'(1);
      else if (wr_cap) wcnt <= wcnt + 1'b1;
      error_q   <= error_q | err_now;
    end
  end

  always_ff @(posedge clk) begin
    if ((rd_state == FETCH) && src_valid) line_q <= src_line;
    if (wr_cap0) begin
      wline_q[0] <= wdata;
      wr_addr_q  <= addr;
    end
    if (wr_cap) wline_q[wcnt] <= wdata;
  end

  assign rvalid   = (rd_state == BURST);
  assign rdata    = rvalid ? line_q[beat_cnt] : '0;
  assign raddr    = cur_addr;
  assign src_req  = src_req_q;
  assign src_addr = cur_addr;
  assign snk_addr = wr_addr_q;
  assign snk_line = wline_q;
  assign error    = error_q;

endmodule

// File: tb/tb_mem_burst_responder.sv
module tb_mem_burst_responder;

  localparam int ADDR_W  = 32;
  localparam int BEAT_W  = 64;
  localparam int BEATS   = 4;
  localparam int QDEPTH  = 4;
  localparam int LATENCY = 2;
  localparam int LINE_W  = BEAT_W * BEATS;

  logic              clk;
  logic              rst_n;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [BEAT_W-1:0] wdata;
  logic              ready;
  logic [ADDR_W-1:0] raddr;
  logic [BEAT_W-1:0] rdata;
  logic              rvalid;
  logic              error;
  logic              src_req;
  logic [ADDR_W-1:0] src_addr;
  logic              src_valid;
  logic [LINE_W-1:0] src_line;
  logic              snk_we;
  logic [ADDR_W-1:0] snk_addr;
  logic [LINE_W-1:0] snk_line;

  mem_burst_responder #(
    .ADDR_W (ADDR_W), .BEAT_W (BEAT_W), .BEATS (BEATS),
    .QDEPTH (QDEPTH), .LATENCY (LATENCY)
  ) dut (
    .clk (clk), .rst_n (rst_n), .read (read), .write (write), .addr (addr),
    .wdata (wdata), .ready (ready), .raddr (raddr), .rdata (rdata),
    .rvalid (rvalid), .error (error), .src_req (src_req), .src_addr (src_addr),
    .src_valid (src_valid), .src_line (src_line), .snk_we (snk_we),
    .snk_addr (snk_addr), .snk_line (snk_line)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Backing-store line content: beat k of line a is {a ^ 0x40, k+1}.
  function automatic logic [BEAT_W-1:0] beat_val(input logic [ADDR_W-1:0] a, input int k);
    return {a ^ 32'h40, 32'(k + 1)};
  endfunction

  function automatic logic [LINE_W-1:0] line_val(input logic [ADDR_W-1:0] a);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = beat_val(a, k);
    return l;
  endfunction

  // Source model: answers a fetch the cycle after src_req unless held.
  logic              src_hold;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;
  initial begin
    src_valid = 1'b0;
    src_line  = '0;
    pend      = 1'b0;
    pend_addr = '0;
    forever begin
      @(posedge clk); #1;
      src_valid = 1'b0;
      if (!rst_n) pend = 1'b0;
      else begin
        if (pend && !src_hold) begin
          src_valid = 1'b1;
          src_line  = line_val(pend_addr);
          pend      = 1'b0;
        end
        if (src_req) begin
          pend      = 1'b1;
          pend_addr = src_addr;
        end
      end
    end
  end

  // Monitor: records beats, burst lengths, commits and fetch activity.
  int                beat_n = 0, run = 0, run_n = 0, snk_n = 0, srcv_n = 0, srcreq_n = 0;
  logic [ADDR_W-1:0] beat_a [64];
  logic [BEAT_W-1:0] beat_d [64];
  int                runs   [32];
  logic [ADDR_W-1:0] snk_a  [8];
  logic [LINE_W-1:0] snk_l  [8];
  int                snk_v  [8];
  initial begin
    forever begin
      @(posedge clk); #2;
      if (!rst_n) run = 0;
      else begin
        if (src_valid) srcv_n++;
        if (src_req) srcreq_n++;
        if (rvalid) begin
          if (beat_n < 64) begin
            beat_a[beat_n] = raddr;
            beat_d[beat_n] = rdata;
          end
          beat_n++;
          run++;
        end else if (run != 0) begin
          if (run_n < 32) runs[run_n] = run;
          run_n++;
          run = 0;
        end
        if (snk_we && snk_n < 8) begin
          snk_a[snk_n] = snk_addr;
          snk_l[snk_n] = snk_line;
          snk_v[snk_n] = srcv_n;
          snk_n++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; src_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beat_n < target && k < budget) begin
      @(posedge clk); #3;
      k++;
    end
    chk("beats_arrived", 1'(beat_n >= target), 1'b1);
  endtask

  typedef struct {
    logic              rd;
    logic [ADDR_W-1:0] a;
    logic              e_ready;
    logic              e_srcreq;
    logic [ADDR_W-1:0] e_srcaddr;
    logic              e_rvalid;
    logic [BEAT_W-1:0] e_rdata;
    logic [ADDR_W-1:0] e_raddr;
    logic              e_error;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [ADDR_W-1:0] a, input logic e_ready,
                              input logic e_srcreq, input logic e_rvalid,
                              input logic [BEAT_W-1:0] e_rdata, input logic e_error);
    vec_t v;
    v.rd = rd; v.a = a; v.e_ready = e_ready; v.e_srcreq = e_srcreq; v.e_srcaddr = 32'h40;
    v.e_rvalid = e_rvalid; v.e_rdata = e_rdata; v.e_raddr = 32'h40; v.e_error = e_error;
    return v;
  endfunction

  vec_t              tbl [15];
  logic [ADDR_W-1:0] rd_addrs [5];
  logic [BEAT_W-1:0] wb [4];
  int                b_beat, b_run, b_req, b_snk, b_srcv;

  initial begin
    // slot i: inputs driven after edge i, outputs show state after edge i.
    tbl[0]  = mk(1, 32'h40, 1, 0, 0, 64'h0, 0);
    tbl[1]  = mk(0, 32'h00, 1, 0, 0, 64'h0, 0);
    tbl[2]  = mk(0, 32'h00, 1, 1, 0, 64'h0, 0);
    tbl[3]  = mk(0, 32'h00, 1, 0, 0, 64'h0, 0);
    tbl[4]  = mk(0, 32'h00, 1, 0, 0, 64'h0, 0);
    tbl[5]  = mk(0, 32'h00, 1, 0, 0, 64'h0, 0);
    tbl[6]  = mk(0, 32'h00, 1, 0, 1, 64'h1, 0);
    tbl[7]  = mk(0, 32'h00, 1, 0, 1, 64'h2, 0);
    tbl[8]  = mk(0, 32'h00, 1, 0, 1, 64'h3, 0);
    tbl[9]  = mk(0, 32'h00, 1, 0, 1, 64'h4, 0);
    tbl[10] = mk(0, 32'h00, 1, 0, 0, 64'h0, 0);
    tbl[11] = mk(1, 32'h24, 1, 0, 0, 64'h0, 0);
    tbl[12] = mk(0, 32'h00, 1, 0, 0, 64'h0, 1);
    tbl[13] = mk(0, 32'h00, 1, 0, 0, 64'h0, 1);
    tbl[14] = mk(0, 32'h00, 1, 0, 0, 64'h0, 1);
    rd_addrs = '{32'h00, 32'h20, 32'h40, 32'h60, 32'h80};
    wb = '{64'hAAAA_0000_0000_000A, 64'hBBBB_0000_0000_000B,
           64'hCCCC_0000_0000_000C, 64'hDDDD_0000_0000_000D};

    rst_n = 1'b1; read = 1'b0; write = 1'b0; addr = '0; wdata = '0; src_hold = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_ready", ready, 1'b1);
    chk("reset_rvalid", rvalid, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_src_req", src_req, 1'b0);
    chk("reset_snk_we", snk_we, 1'b0);
    chk("reset_raddr", raddr, 32'h0);
    chk("reset_rdata", rdata, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read of 0x40, then a misaligned read of 0x24.
    for (int i = 0; i < 15; i++) begin
      tick();
      read = tbl[i].rd;
      addr = tbl[i].a;
      #2;
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_src_req", i), src_req, tbl[i].e_srcreq);
      if (tbl[i].e_srcreq) chk($sformatf("tbl%0d_src_addr", i), src_addr, tbl[i].e_srcaddr);
      chk($sformatf("tbl%0d_rvalid", i), rvalid, tbl[i].e_rvalid);
      if (tbl[i].e_rvalid) begin
        chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].e_rdata);
        chk($sformatf("tbl%0d_raddr", i), raddr, tbl[i].e_raddr);
      end
      chk($sformatf("tbl%0d_error", i), error, tbl[i].e_error);
    end

    // Back-to-back reads with the source stalled: the first is popped into
    // FETCH at once, so the queue itself fills on the fifth accept.
    tick(); do_reset();
    src_hold = 1'b1;
    b_beat = beat_n; b_run = run_n; b_req = srcreq_n;
    for (int i = 0; i < 5; i++) begin
      tick();
      read = 1'b1; addr = rd_addrs[i];
      #2;
      chk($sformatf("fill%0d_ready", i), ready, 1'b1);
    end
    tick();
    read = 1'b1; addr = 32'hA0;
    #2;
    chk("full_ready", ready, 1'b0);
    chk("full_error_before", error, 1'b0);
    tick();
    read = 1'b0;
    #2;
    chk("full_read_error", error, 1'b1);
    repeat (5) tick();
    chk("stalled_fetch_count", srcreq_n - b_req, 1);
    src_hold = 1'b0;
    wait_beats(b_beat + 20, 300);
    repeat (4) tick();
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < BEATS; j++) begin
        chk($sformatf("order_b%0d_k%0d_raddr", b, j), beat_a[b_beat + b*BEATS + j], rd_addrs[b]);
        chk($sformatf("order_b%0d_k%0d_rdata", b, j), beat_d[b_beat + b*BEATS + j], beat_val(rd_addrs[b], j));
      end
      chk($sformatf("burst%0d_len", b), runs[b_run + b], BEATS);
    end
    chk("order_total_beats", beat_n - b_beat, 20);
    chk("order_total_fetches", srcreq_n - b_req, 5);

    // Write to 0x80 while two reads are outstanding.
    tick(); do_reset();
    src_hold = 1'b1;
    b_beat = beat_n; b_snk = snk_n; b_srcv = srcv_n;
    tick(); read = 1'b1; addr = 32'h00;
    tick(); read = 1'b1; addr = 32'h20;
    tick(); read = 1'b0; write = 1'b1; addr = 32'h80; wdata = wb[0];
    #2 chk("wr_ready_beat0", ready, 1'b1);
    for (int k = 1; k < BEATS; k++) begin
      tick(); wdata = wb[k];
      #2 chk($sformatf("wr_ready_beat%0d", k), ready, 1'b0);
    end
    tick(); write = 1'b0;
    repeat (6) tick();
    chk("wr_no_commit_while_held", snk_n - b_snk, 0);
    src_hold = 1'b0;
    wait_beats(b_beat + 8, 200);
    repeat (6) tick();
    chk("wr_commit_count", snk_n - b_snk, 1);
    chk("wr_commit_after_fetches", snk_v[b_snk] - b_srcv, 2);
    chk("wr_snk_addr", snk_a[b_snk], 32'h80);
    chk("wr_snk_line", snk_l[b_snk], {wb[3], wb[2], wb[1], wb[0]});
    chk("wr_read0_addr", beat_a[b_beat], 32'h00);
    chk("wr_read1_addr", beat_a[b_beat + 4], 32'h20);
    chk("wr_read1_data", beat_d[b_beat + 5], beat_val(32'h20, 1));
    chk("wr_no_error", error, 1'b0);

    // Write aborted after two beats.
    tick(); do_reset();
    b_snk = snk_n;
    tick(); write = 1'b1; addr = 32'h100; wdata = 64'h1;
    tick(); wdata = 64'h2;
    #2 chk("abort_ready_collect", ready, 1'b0);
    tick(); write = 1'b0;
    #2 chk("abort_error_pre", error, 1'b0);
    tick();
    #2;
    chk("abort_error", error, 1'b1);
    chk("abort_ready_back", ready, 1'b1);
    repeat (6) tick();
    chk("abort_no_commit", snk_n - b_snk, 0);

    // read and write together: read dropped, write still completes.
    tick(); do_reset();
    b_snk = snk_n; b_req = srcreq_n;
    tick(); read = 1'b1; write = 1'b1; addr = 32'h40; wdata = wb[3];
    for (int k = 1; k < BEATS; k++) begin
      tick(); read = 1'b0; wdata = wb[BEATS - 1 - k];
      if (k == 1) begin
        #2 chk("rw_error", error, 1'b1);
      end
    end
    tick(); write = 1'b0;
    repeat (6) tick();
    chk("rw_read_dropped", srcreq_n - b_req, 0);
    chk("rw_commit_count", snk_n - b_snk, 1);
    chk("rw_snk_line", snk_l[b_snk], {wb[0], wb[1], wb[2], wb[3]});

    // Reset asserted on the second beat of a burst.
    tick(); do_reset();
    b_beat = beat_n;
    tick(); read = 1'b1; addr = 32'h40;
    tick(); read = 1'b1; addr = 32'h04;
    tick(); read = 1'b0;
    #2 chk("rst_pre_error", error, 1'b1);
    wait_beats(b_beat + 2, 50);
    chk("rst_beat2_rvalid", rvalid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_rvalid", rvalid, 1'b0);
    chk("rst_async_ready", ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    chk("rst_after_error", error, 1'b0);
    chk("rst_after_ready", ready, 1'b1);
    b_beat = beat_n; b_req = srcreq_n;
    repeat (10) tick();
    chk("rst_no_fetch", srcreq_n - b_req, 0);
    chk("rst_no_beats", beat_n - b_beat, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
